// File: rtl/npu_pkg.sv
// Shared NPU definitions: default frame geometry, sample width and the
// pooling-stage FSM state encoding used by the conv/pool pipeline.
package npu_pkg;

    localparam int NPU_IN_WIDTH  = 30;
    localparam int NPU_IN_HEIGHT = 30;
    localparam int NPU_DATA_W    = 22;

    typedef logic [1:0] pool_state_t;

    localparam pool_state_t ST_IDLE = 2'd0;
    localparam pool_state_t ST_RUN  = 2'd1;
    localparam pool_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/max_cmp.sv
// Combinational signed maximum of two DATA_W-bit samples.
module max_cmp
    import npu_pkg::*;
#(
    parameter int DATA_W = NPU_DATA_W
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] y
);

    assign y = (a >= b) ? a : b;

endmodule

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 signed max pooling over a raster-ordered conv result stream.
// Define MAX_POOL_RELU_EN to clamp negative samples to zero before pooling.
module max_pool_2x2
    import npu_pkg::*;
#(
    parameter int IN_WIDTH  = NPU_IN_WIDTH,
    parameter int IN_HEIGHT = NPU_IN_HEIGHT,
    parameter int DATA_W    = NPU_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_signal,
    input  logic signed [DATA_W-1:0] conv_in,
    input  logic                     conv_valid,
    output logic signed [DATA_W-1:0] pool_out,
    output logic                     pool_valid,
    output logic                     done_signal
);

    localparam int XW = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
    localparam int YW = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam int NB = (IN_WIDTH / 2 > 0) ? IN_WIDTH / 2 : 1;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(IN_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IN_HEIGHT - 1);

    // An odd height leaves an unpaired final row that must not touch the buffer;
    // only an even/even frame has a result still in flight after the last sample.
    localparam bit TAIL_ROW      = (IN_HEIGHT % 2) != 0;
    localparam bit RESULT_AT_END = ((IN_WIDTH % 2) == 0) && ((IN_HEIGHT % 2) == 0);

    pool_state_t              state;
    logic [XW-1:0]            in_x;
    logic [YW-1:0]            in_y;
    logic signed [DATA_W-1:0] h_hold;
    logic signed [DATA_W-1:0] row_buf [NB];
    logic                     last_pending;

    logic signed [DATA_W-1:0] sample;
    logic signed [DATA_W-1:0] h_pair;
    logic signed [DATA_W-1:0] v_max;
    logic                     accept;
    logic                     last_sample;
    logic                     row_writable;
    logic [BW-1:0]            buf_idx;

`ifdef MAX_POOL_RELU_EN
    assign sample = conv_in[DATA_W-1] ? '0 : conv_in;
`else
    assign sample = conv_in;
`endif

    assign accept       = (state == ST_RUN) && conv_valid && !last_pending;
    assign last_sample  = (in_x == X_LAST) && (in_y == Y_LAST);
    assign row_writable = !(TAIL_ROW && (in_y == Y_LAST));
    assign buf_idx      = BW'(in_x >> 1);

    max_cmp #(.DATA_W(DATA_W)) u_h_max (
        .a (h_hold),
        .b (sample),
        .y (h_pair)
    );

    max_cmp #(.DATA_W(DATA_W)) u_v_max (
        .a (row_buf[buf_idx]),
        .b (h_pair),
        .y (v_max)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            in_x         <= '0;
            in_y         <= '0;
            h_hold       <= '0;
            pool_out     <= '0;
            pool_valid   <= 1'b0;
            last_pending <= 1'b0;
            for (int i = 0; i < NB; i++) begin
                row_buf[i] <= '0;
            end
        end else begin
            pool_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    in_x         <= '0;
                    in_y         <= '0;
                    last_pending <= 1'b0;
                    if (start_signal) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Hold RUN one extra cycle so DONE follows the final pool_valid.
                    if (last_pending) begin
                        state <= ST_DONE;
                    end else if (accept) begin
                        if (!in_x[0]) begin
                            h_hold <= sample;
                        end else if (!in_y[0]) begin
                            if (row_writable) begin
                                row_buf[buf_idx] <= h_pair;
                            end
                        end else begin
                            pool_out   <= v_max;
                            pool_valid <= 1'b1;
                        end

                        if (in_x == X_LAST) begin
                            in_x <= '0;
                            in_y <= (in_y == Y_LAST) ? '0 : in_y + YW'(1);
                        end else begin
                            in_x <= in_x + XW'(1);
                        end

                        if (last_sample) begin
                            if (RESULT_AT_END) begin
                                last_pending <= 1'b1;
                            end else begin
                                state <= ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign done_signal = (state == ST_DONE);

endmodule

// File: doc/max_pool_2x2.md
MAX_POOL_2X2 -- requirements
Module: max_pool_2x2

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 30: conv results per row.
REQ-002 SHALL have parameter IN_HEIGHT, default 30: conv result rows per frame.
REQ-003 SHALL have parameter DATA_W, default 22: signed sample width.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port start_signal, input, 1: frame start pulse, honoured in IDLE only.
REQ-007 SHALL have port conv_in, input, signed DATA_W: conv result sample, raster order.
REQ-008 SHALL have port conv_valid, input, 1: conv_in valid this cycle (no backpressure).
REQ-009 SHALL have port pool_out, output, signed DATA_W: pooled result.
REQ-010 SHALL have port pool_valid, output, 1: pool_out valid, one-cycle pulse per result.
REQ-011 SHALL have port done_signal, output, 1: one-cycle pulse at end of frame.

Function
REQ-012 SHALL implement FSM IDLE -> RUN on start_signal; RUN -> DONE after last sample accepted and its result emitted; DONE -> IDLE unconditionally.
REQ-013 SHALL ignore conv_valid in IDLE and DONE; SHALL ignore start_signal in RUN and DONE.
REQ-014 SHALL keep counters in_x (0..IN_WIDTH-1) and in_y (0..IN_HEIGHT-1), cleared in IDLE, advanced per accepted sample; in_x wraps to 0 and increments in_y at IN_WIDTH-1.
REQ-015 SHALL on even in_x register sample as h_hold; on odd in_x form h_pair = signed max(h_hold, conv_in).
REQ-016 SHALL on even in_y write h_pair into row buffer entry in_x>>1 (IN_WIDTH/2 entries, DATA_W each).
REQ-017 SHALL on odd in_y register pool_out = signed max(row_buf[in_x>>1], h_pair) and pulse pool_valid exactly one cycle after the accepting edge.
REQ-018 SHALL produce floor(IN_WIDTH/2) x floor(IN_HEIGHT/2) results per frame, raster order; trailing odd column/row is dropped (no output, no buffer write).
REQ-019 SHALL use full-width signed compare; ties select either operand (identical value); no width growth.
REQ-020 SHALL assert done_signal in DONE only, i.e. the cycle after the final pool_valid (or after the last accepted sample when no result is pending).
REQ-021 SHALL accept back-to-back conv_valid every cycle and arbitrary gaps between samples without state change.
REQ-022 SHALL hold pool_out between pulses; pool_out is valid only when pool_valid=1.

Reset
REQ-023 SHALL on rst: state=IDLE, in_x=in_y=0, h_hold=0, row buffer=0, pool_out=0, pool_valid=0, done_signal=0.
REQ-024 SHALL abort a frame on rst mid-RUN with no further pool_valid or done_signal until a new start_signal.

Configuration
REQ-025 SHALL use macro MAX_POOL_RELU_EN: when defined, each conv_in is clamped to 0 if negative before pooling (outputs >= 0); when undefined, raw signed samples are pooled.

Structure
REQ-026 SHALL place the FSM state enum, DATA_W default and IN_WIDTH/IN_HEIGHT defaults in shared package npu_pkg, shared with the conv stage.
REQ-027 SHALL implement signed max as sub-module max_cmp (combinational, DATA_W-parameterised), instantiated twice.

Verification
REQ-028 SHALL test 4x4 frame, samples 0..15 raster, no RELU -> pool_out 5,7,13,15, then done_signal next cycle.
REQ-029 SHALL test 30x30 frame, back-to-back valid -> exactly 225 pool_valid pulses, each 1 cycle after the odd/odd sample; one done pulse.
REQ-030 SHALL test 4x4 frame all -100: MAX_POOL_RELU_EN undefined -> four outputs -100; defined -> four outputs 0.
REQ-031 SHALL test 5x5 frame, value = 10*y+x -> outputs 11,13,31,33 only; column 4/row 4 ignored; done after last sample.
REQ-032 SHALL test conv_valid before start_signal plus rst asserted at sample 20 of a 30x30 frame -> no output pre-start, outputs stop at reset, clean 225-result frame after restart.
REQ-033 SHALL test random conv_valid gaps (30% idle) with signed random data -> scoreboard match against reference model, done pulse count 1.
